// File: rtl/store_checker.sv
// store_checker: watches CPU data-memory stores against a programmed table of
// expected (address, data) pairs and reports pass, fail or timeout.
module store_checker #(
   parameter int NUM_EXP = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1000,
   parameter int ORDERED = 1,
   localparam int IW     = $clog2(NUM_EXP) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_idx,
   input  logic [AW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_data,
   input  logic          memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [DW-1:0] writedata,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timed_out,
   output logic [IW-1:0] match_cnt,
   output logic [AW-1:0] err_addr,
   output logic [DW-1:0] err_data,
   output logic [31:0]   cycles
);

   // state | meaning
   // IDLE  | table writable, waiting for start
   // RUN   | monitoring stores, counting cycles
   // PASS  | every table entry matched
   // FAIL  | mismatching store or timeout
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t             state;
   logic [AW-1:0]      tab_addr [NUM_EXP];
   logic [DW-1:0]      tab_data [NUM_EXP];
   logic [NUM_EXP-1:0] matched;
   logic [NUM_EXP-1:0] set_vec;
   logic               hit_any;
   logic               tgt_found;
   logic               tgt_deq;
   logic               old_seen;
   logic               old_ok;
   logic               st_match;
   logic               st_fail;
   logic [31:0]        cycles_nx;

   assign cycles_nx = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

   always_comb begin
      hit_any   = 1'b0;
      tgt_found = 1'b0;
      tgt_deq   = 1'b0;
      old_seen  = 1'b0;
      old_ok    = 1'b0;
      st_match  = 1'b0;
      st_fail   = 1'b0;
      set_vec   = '0;
      for (int i = 0; i < NUM_EXP; i++)
         if (tab_addr[i] == dataadr) hit_any = 1'b1;
      if (ORDERED != 0) begin
         for (int i = 0; i < NUM_EXP; i++)
            if (match_cnt == IW'(i) && tab_addr[i] == dataadr && tab_data[i] == writedata) begin
               st_match   = 1'b1;
               set_vec[i] = 1'b1;
            end
         st_fail = hit_any && !st_match;
      end else begin
         // descending scan so the lowest-index unmatched entry wins
         for (int i = NUM_EXP - 1; i >= 0; i--)
            if (!matched[i] && tab_addr[i] == dataadr) begin
               tgt_found  = 1'b1;
               tgt_deq    = (tab_data[i] == writedata);
               set_vec    = '0;
               set_vec[i] = 1'b1;
            end
         for (int i = 0; i < NUM_EXP; i++)
            if (matched[i] && tab_addr[i] == dataadr) begin
               old_seen = 1'b1;
               if (tab_data[i] == writedata) old_ok = 1'b1;
            end
         st_match = tgt_found && tgt_deq;
         st_fail  = tgt_found ? !tgt_deq : (old_seen && !old_ok);
      end
      st_match = st_match && memwrite;
      st_fail  = st_fail && memwrite;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timed_out <= 1'b0;
         match_cnt <= '0;
         err_addr  <= '0;
         err_data  <= '0;
         cycles    <= '0;
         matched   <= '0;
         for (int i = 0; i < NUM_EXP; i++) begin
            tab_addr[i] <= '0;
            tab_data[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               for (int i = 0; i < NUM_EXP; i++)
                  if (cfg_we && cfg_idx == IW'(i)) begin
                     tab_addr[i] <= cfg_addr;
                     tab_data[i] <= cfg_data;
                  end
            end
            S_RUN: begin
               cycles <= cycles_nx;
               if (st_match) begin
                  matched   <= matched | set_vec;
                  match_cnt <= match_cnt + IW'(1);
               end
               // a final match on the timeout edge takes precedence
               if (st_match && match_cnt == IW'(NUM_EXP - 1)) begin
                  state <= S_PASS;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end else if (st_fail) begin
                  state    <= S_FAIL;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  fail     <= 1'b1;
                  err_addr <= dataadr;
                  err_data <= writedata;
               end else if (cycles_nx == 32'(TIMEOUT)) begin
                  state     <= S_FAIL;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  fail      <= 1'b1;
                  timed_out <= 1'b1;
               end
            end
            default: ;
         endcase
         if (start && state != S_RUN) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timed_out <= 1'b0;
            match_cnt <= '0;
            err_addr  <= '0;
            err_data  <= '0;
            cycles    <= '0;
            matched   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: three instances (ordered x4, any-order x4, single
// entry) driven in parallel and compared every cycle with a table-level model.
module tb_store_checker;

   localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
   localparam int MN  [3] = '{4, 4, 1};
   localparam int MORD[3] = '{1, 0, 1};
   localparam int MTO [3] = '{60, 60, 20};

   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, cfg_we = 1'b0, memwrite = 1'b0;
   logic [2:0]  cfg_idx = '0;
   logic [0:0]  cfg_idx1 = '0;
   logic [31:0] cfg_addr = '0, cfg_data = '0, dataadr = '0, writedata = '0;

   logic        o_busy, o_done, o_pass, o_fail, o_tmo;
   logic [2:0]  o_mcnt;
   logic [31:0] o_ea, o_ed, o_cyc;
   logic        a_busy, a_done, a_pass, a_fail, a_tmo;
   logic [2:0]  a_mcnt;
   logic [31:0] a_ea, a_ed, a_cyc;
   logic        s_busy, s_done, s_pass, s_fail, s_tmo;
   logic [0:0]  s_mcnt;
   logic [31:0] s_ea, s_ed, s_cyc;

   int n_checks = 0;
   int n_errors = 0;

   int          mst  [3];
   int          mcnt [3];
   logic [31:0] mcyc [3], merra [3], merrd [3];
   bit          mtmo [3];
   bit          mmat [3][4];
   logic [31:0] ta [3][4], td [3][4];

   store_checker #(.NUM_EXP(4), .TIMEOUT(60), .ORDERED(1)) u_ord (
      .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(o_busy), .done(o_done), .pass(o_pass), .fail(o_fail),
      .timed_out(o_tmo), .match_cnt(o_mcnt), .err_addr(o_ea), .err_data(o_ed), .cycles(o_cyc));

   store_checker #(.NUM_EXP(4), .TIMEOUT(60), .ORDERED(0)) u_any (
      .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
      .timed_out(a_tmo), .match_cnt(a_mcnt), .err_addr(a_ea), .err_data(a_ed), .cycles(a_cyc));

   store_checker #(.NUM_EXP(1), .TIMEOUT(20), .ORDERED(1)) u_one (
      .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx1),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
      .timed_out(s_tmo), .match_cnt(s_mcnt), .err_addr(s_ea), .err_data(s_ed), .cycles(s_cyc));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mst[k] = M_IDLE; mcnt[k] = 0; mcyc[k] = '0; merra[k] = '0; merrd[k] = '0; mtmo[k] = 1'b0;
         for (int j = 0; j < 4; j++) begin
            mmat[k][j] = 1'b0; ta[k][j] = '0; td[k][j] = '0;
         end
      end
   endtask

   task automatic arm(input int k);
      mst[k] = M_RUN; mcnt[k] = 0; mcyc[k] = '0; merra[k] = '0; merrd[k] = '0; mtmo[k] = 1'b0;
      for (int j = 0; j < 4; j++) mmat[k][j] = 1'b0;
   endtask

   // one clock edge of the expected behaviour for instance k
   task automatic mstep(input int k, input int idx);
      int tgt;
      int res;
      bit seen, ok;
      tgt = -1; res = 0; seen = 1'b0; ok = 1'b0;
      case (mst[k])
         M_IDLE: begin
            if (cfg_we && idx < MN[k]) begin
               ta[k][idx] = cfg_addr; td[k][idx] = cfg_data;
            end
            if (start) arm(k);
         end
         M_RUN: begin
            if (memwrite) begin
               if (MORD[k] != 0) begin
                  if (ta[k][mcnt[k]] == dataadr && td[k][mcnt[k]] == writedata) begin
                     res = 1; tgt = mcnt[k];
                  end else
                     for (int j = 0; j < MN[k]; j++) if (ta[k][j] == dataadr) res = 2;
               end else begin
                  for (int j = 0; j < MN[k]; j++)
                     if (tgt < 0 && !mmat[k][j] && ta[k][j] == dataadr) tgt = j;
                  if (tgt >= 0) res = (td[k][tgt] == writedata) ? 1 : 2;
                  else begin
                     for (int j = 0; j < MN[k]; j++)
                        if (mmat[k][j] && ta[k][j] == dataadr) begin
                           seen = 1'b1;
                           if (td[k][j] == writedata) ok = 1'b1;
                        end
                     if (seen && !ok) res = 2;
                  end
               end
            end
            if (mcyc[k] != 32'hFFFF_FFFF) mcyc[k] = mcyc[k] + 1;
            if (res == 1) begin
               mmat[k][tgt] = 1'b1; mcnt[k]++;
            end
            if (mcnt[k] == MN[k]) mst[k] = M_PASS;
            else if (res == 2) begin
               mst[k] = M_FAIL; merra[k] = dataadr; merrd[k] = writedata;
            end else if (mcyc[k] == 32'(MTO[k])) begin
               mst[k] = M_FAIL; mtmo[k] = 1'b1;
            end
         end
         default: if (start) arm(k);
      endcase
   endtask

   always @(posedge clk)
      if (!reset) begin
         mstep(0, int'(cfg_idx));
         mstep(1, int'(cfg_idx));
         mstep(2, int'(cfg_idx1));
      end

   task automatic check_inst(input string nm, input int k, input logic busy, input logic done,
                             input logic pass, input logic fail, input logic tmo,
                             input logic [31:0] mc, input logic [31:0] ea,
                             input logic [31:0] ed, input logic [31:0] cyc);
      check_eq({nm, ".busy"}, 32'(busy), 32'(mst[k] == M_RUN));
      check_eq({nm, ".done"}, 32'(done), 32'(mst[k] == M_PASS || mst[k] == M_FAIL));
      check_eq({nm, ".pass"}, 32'(pass), 32'(mst[k] == M_PASS));
      check_eq({nm, ".fail"}, 32'(fail), 32'(mst[k] == M_FAIL));
      check_eq({nm, ".timed_out"}, 32'(tmo), 32'(mtmo[k]));
      check_eq({nm, ".match_cnt"}, mc, 32'(mcnt[k]));
      check_eq({nm, ".err_addr"}, ea, merra[k]);
      check_eq({nm, ".err_data"}, ed, merrd[k]);
      check_eq({nm, ".cycles"}, cyc, mcyc[k]);
   endtask

   task automatic check_all();
      check_inst("ord", 0, o_busy, o_done, o_pass, o_fail, o_tmo, 32'(o_mcnt), o_ea, o_ed, o_cyc);
      check_inst("any", 1, a_busy, a_done, a_pass, a_fail, a_tmo, 32'(a_mcnt), a_ea, a_ed, a_cyc);
      check_inst("one", 2, s_busy, s_done, s_pass, s_fail, s_tmo, 32'(s_mcnt), s_ea, s_ed, s_cyc);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      tick();
      reset = 1'b0;
   endtask

   task automatic cfg(input int i4, input int i1, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = 3'(i4); cfg_idx1 = 1'(i1); cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; dataadr = a; writedata = d;
      tick();
      memwrite = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_table();
      cfg(0, 1, 32'h50, 32'd7);
      cfg(1, 0, 32'h54, 32'd88);
      cfg(2, 1, 32'h58, 32'd3);
      cfg(3, 1, 32'h54, 32'd21);
      cfg(5, 1, 32'h99, 32'h99);
   endtask

   task automatic ordered_seq();
      store(32'h50, 32'd7);
      store(32'h60, 32'd5);
      store(32'h54, 32'd88);
      store(32'h58, 32'd3);
      store(32'h54, 32'd21);
   endtask

   initial begin
      int j;
      do_reset();
      check_eq("rst_cycles", s_cyc, 32'd0);
      check_eq("rst_busy", 32'(o_busy), 32'd0);
      load_table();

      go();
      store(32'h54, 32'd88);
      check_eq("t1_pass", 32'(s_pass), 32'd1);
      check_eq("t1_mcnt", 32'(s_mcnt), 32'd1);
      check_eq("t1_done", 32'(s_done), 32'd1);
      check_eq("t3_ord_fail", 32'(o_fail), 32'd1);
      check_eq("t3_ord_eaddr", o_ea, 32'h54);

      go();
      store(32'h60, 32'd1);
      check_eq("t3_scratch_ignored", 32'(s_busy), 32'd1);
      store(32'h54, 32'd87);
      check_eq("t2_fail", 32'(s_fail), 32'd1);
      check_eq("t2_eaddr", s_ea, 32'h54);
      check_eq("t2_edata", s_ed, 32'd87);
      check_eq("t2_tmo", 32'(s_tmo), 32'd0);

      go();
      store(32'h58, 32'd3);
      store(32'h54, 32'd88);
      store(32'h54, 32'd21);
      store(32'h54, 32'd88);
      store(32'h50, 32'd7);
      check_eq("t3_any_pass", 32'(a_pass), 32'd1);
      check_eq("t3_any_mcnt", 32'(a_mcnt), 32'd4);

      go();
      ordered_seq();
      check_eq("ord_pass", 32'(o_pass), 32'd1);
      check_eq("ord_mcnt", 32'(o_mcnt), 32'd4);

      go();
      check_eq("t6_busy", 32'(o_busy), 32'd1);
      check_eq("t6_mcnt", 32'(o_mcnt), 32'd0);
      check_eq("t6_cycles", o_cyc, 32'd0);
      repeat (20) tick();
      check_eq("t4_fail", 32'(s_fail), 32'd1);
      check_eq("t4_tmo", 32'(s_tmo), 32'd1);
      check_eq("t4_cycles", s_cyc, 32'd20);
      check_eq("t4_eaddr", s_ea, 32'd0);
      repeat (41) tick();
      check_eq("t4_ord_tmo", 32'(o_tmo), 32'd1);

      go();
      repeat (19) tick();
      store(32'h54, 32'd88);
      check_eq("t4_edge_pass", 32'(s_pass), 32'd1);
      check_eq("t4_edge_cycles", s_cyc, 32'd20);

      do_reset();
      load_table();
      go();
      store(32'h50, 32'd7);
      reset = 1'b1;
      model_reset();
      #1;
      check_eq("t5_rst_mcnt", 32'(o_mcnt), 32'd0);
      check_eq("t5_rst_busy", 32'(o_busy), 32'd0);
      check_eq("t5_rst_cycles", o_cyc, 32'd0);
      check_all();
      tick();
      reset = 1'b0;

      load_table();
      go();
      cfg(0, 0, 32'h50, 32'd99);
      cfg(1, 1, 32'h54, 32'd77);
      ordered_seq();
      go();
      ordered_seq();
      check_eq("t5_rerun_ord", 32'(o_pass), 32'd1);
      check_eq("t5_rerun_any", 32'(a_pass), 32'd1);
      check_eq("t5_rerun_one", 32'(s_pass), 32'd1);

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else begin
            start    = ($urandom_range(0, 29) == 0);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_idx  = 3'($urandom_range(0, 7));
            cfg_idx1 = 1'($urandom_range(0, 1));
            cfg_addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
            cfg_data = 32'($urandom_range(0, 3));
            memwrite = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
               j = ($urandom_range(0, 1) == 1 && mcnt[0] < 4) ? mcnt[0] : $urandom_range(0, 3);
               dataadr   = ta[0][j];
               writedata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : td[0][j];
            end else begin
               dataadr   = 32'h40 + 32'(4 * $urandom_range(0, 7));
               writedata = 32'($urandom_range(0, 3));
            end
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
